// File: rtl/uart_rx_timing_counter.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_timing_counter
// Description : Bit and frame timing for an oversampling UART receiver.
//               When counter_enable rises, the frame configuration is latched.
//               The block then counts clocks within each bit (edge_count) and
//               bits within the frame (bit_count). It flags three
//               majority-vote sample points around the bit centre, the end of
//               every bit and the end of the frame.
// Ports       : clk            - clock, rising edge
//               rst            - asynchronous reset, active low
//               Prescale       - clocks per bit P (4..2^PRESC_W-1)
//               counter_enable - frame in progress (low = idle/abort)
//               PAR_EN         - frame carries a parity bit
//               STOP2          - frame carries two stop bits
//               data_len       - data bits per frame (5..DATA_BITS_MAX)
//               edge_count     - clock index within current bit
//               bit_count      - bit index within frame, 0 = start bit
//               sample_strobe  - one of the three sample edges
//               sample_last    - final sample edge
//               bit_done       - last clock of a bit
//               frame_done     - last clock of the frame
//               cfg_err        - configuration at frame start was illegal
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_timing_counter #(
  parameter int PRESC_W       = 6,
  parameter int DATA_BITS_MAX = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PRESC_W-1:0] Prescale,
  input  logic               counter_enable,
  input  logic               PAR_EN,
  input  logic               STOP2,
  input  logic [3:0]         data_len,
  output logic [PRESC_W-1:0] edge_count,
  output logic [3:0]         bit_count,
  output logic               sample_strobe,
  output logic               sample_last,
  output logic               bit_done,
  output logic               frame_done,
  output logic               cfg_err
);

  localparam logic [PRESC_W-1:0] c_PRESC_MIN = PRESC_W'(4);
  localparam logic [PRESC_W-1:0] c_ONE       = PRESC_W'(1);
  localparam logic [3:0]         c_DATA_MIN  = 4'd5;
  localparam logic [3:0]         c_DATA_MAX  = 4'(DATA_BITS_MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t             r_state;
  logic [PRESC_W-1:0] r_edge;
  logic [3:0]         r_bit;
  logic [PRESC_W-1:0] r_presc;
  logic [4:0]         r_last_bit;   // index of final bit, L-1
  logic               r_cfg_err;

  logic               w_cfg_ok;
  logic [4:0]         w_last_bit_in;
  logic [PRESC_W-1:0] w_p_m1;
  logic [PRESC_W-1:0] w_mid;
  logic               w_in_count;
  logic               w_bit_end;
  logic               w_frame_end;

  assign w_cfg_ok = (Prescale >= c_PRESC_MIN) &&
                    (data_len >= c_DATA_MIN) && (data_len <= c_DATA_MAX);

  // L-1 = data_len + PAR_EN + stop bits (the start bit cancels the -1)
  assign w_last_bit_in = {1'b0, data_len} + {4'b0, PAR_EN} + (STOP2 ? 5'd2 : 5'd1);

  assign w_p_m1      = r_presc - c_ONE;
  assign w_mid       = r_presc >> 1;
  assign w_in_count  = (r_state == COUNT);
  assign w_bit_end   = w_in_count && (r_edge == w_p_m1);
  assign w_frame_end = w_bit_end && ({1'b0, r_bit} == r_last_bit);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_edge     <= '0;
      r_bit      <= '0;
      r_presc    <= '0;
      r_last_bit <= '0;
      r_cfg_err  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_edge <= '0;
          r_bit  <= '0;
          if (!counter_enable) begin
            r_cfg_err <= 1'b0;
          end else if (!r_cfg_err) begin
            // A rejected configuration stays rejected until enable drops,
            // so a frame can only start on a fresh enable.
            if (w_cfg_ok) begin
              r_presc    <= Prescale;
              r_last_bit <= w_last_bit_in;
              r_state    <= COUNT;
            end else begin
              r_cfg_err <= 1'b1;
            end
          end
        end
        COUNT: begin
          if (!counter_enable) begin
            r_state <= IDLE;
            r_edge  <= '0;
            r_bit   <= '0;
          end else if (r_edge == w_p_m1) begin
            r_edge <= '0;
            if ({1'b0, r_bit} == r_last_bit) begin
              r_bit   <= '0;
              r_state <= HOLD;
            end else begin
              r_bit <= r_bit + 4'd1;
            end
          end else begin
            r_edge <= r_edge + c_ONE;
          end
        end
        HOLD: begin
          r_edge <= '0;
          r_bit  <= '0;
          if (!counter_enable) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_edge  <= '0;
          r_bit   <= '0;
        end
      endcase
    end
  end

  // Strobes decode the registered counters so they line up with edge_count.
  // P >= 4 guarantees w_mid >= 2, so w_mid - 1 never underflows.
  assign edge_count    = r_edge;
  assign bit_count     = r_bit;
  assign sample_strobe = w_in_count && ((r_edge == w_mid - c_ONE) ||
                                        (r_edge == w_mid) ||
                                        (r_edge == w_mid + c_ONE));
  assign sample_last   = w_in_count && (r_edge == w_mid + c_ONE);
  assign bit_done      = w_bit_end;
  assign frame_done    = w_frame_end;
  assign cfg_err       = r_cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_timing_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_timing_counter
// Description : Directed self-checking bench for uart_rx_timing_counter.
//               The expected frame_done latency is queued when a frame is
//               started and popped when the DUT raises frame_done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_timing_counter;

  localparam int PW = 6;
  localparam int DM = 9;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [PW-1:0] Prescale = '0;
  logic          counter_enable = 1'b0;
  logic          PAR_EN = 1'b0;
  logic          STOP2 = 1'b0;
  logic [3:0]    data_len = '0;
  logic [PW-1:0] edge_count;
  logic [3:0]    bit_count;
  logic          sample_strobe;
  logic          sample_last;
  logic          bit_done;
  logic          frame_done;
  logic          cfg_err;

  int total = 0;
  int bad   = 0;
  int sb[$];

  uart_rx_timing_counter #(.PRESC_W(PW), .DATA_BITS_MAX(DM)) dut (
    .clk(clk), .rst(rst), .Prescale(Prescale), .counter_enable(counter_enable),
    .PAR_EN(PAR_EN), .STOP2(STOP2), .data_len(data_len),
    .edge_count(edge_count), .bit_count(bit_count),
    .sample_strobe(sample_strobe), .sample_last(sample_last),
    .bit_done(bit_done), .frame_done(frame_done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_edge"},   32'(edge_count),    0);
    chk({tag, "_bit"},    32'(bit_count),     0);
    chk({tag, "_strobe"}, 32'(sample_strobe), 0);
    chk({tag, "_last"},   32'(sample_last),   0);
    chk({tag, "_bdone"},  32'(bit_done),      0);
    chk({tag, "_fdone"},  32'(frame_done),    0);
  endtask

  // Runs one frame; chg_k >= 1 alters the live config at that cycle,
  // abort_k >= 1 drops counter_enable at that cycle.
  task automatic run_frame(input int p, input bit par, input bit st, input int dl,
                           input int chg_k, input int abort_k);
    int len, m, e, b;
    len = 1 + dl + int'(par) + (st ? 2 : 1);
    m   = p / 2;
    @(negedge clk);
    Prescale = PW'(p); PAR_EN = par; STOP2 = st; data_len = 4'(dl);
    counter_enable = 1'b1;
    if (abort_k < 1) sb.push_back(p * len);
    for (int k = 1; k <= p * len; k++) begin
      @(negedge clk);
      e = (k - 1) % p;
      b = (k - 1) / p;
      chk("edge_count",    32'(edge_count),    e);
      chk("bit_count",     32'(bit_count),     b);
      chk("sample_strobe", 32'(sample_strobe), (e >= m - 1 && e <= m + 1) ? 1 : 0);
      chk("sample_last",   32'(sample_last),   (e == m + 1) ? 1 : 0);
      chk("bit_done",      32'(bit_done),      (e == p - 1) ? 1 : 0);
      chk("frame_done",    32'(frame_done),    (e == p - 1 && b == len - 1) ? 1 : 0);
      chk("cfg_err_frame", 32'(cfg_err),       0);
      if (frame_done === 1'b1) begin
        if (sb.size() == 0) chk("unexpected_frame_done", 32'(frame_done), 0);
        else                chk("frame_latency", k, sb.pop_front());
      end
      if (k == chg_k) begin
        Prescale = PW'(32); PAR_EN = ~par; STOP2 = ~st; data_len = 4'd5;
      end
      if (k == abort_k) begin
        counter_enable = 1'b0;
        break;
      end
    end
    if (abort_k >= 1) begin
      @(negedge clk);
      check_idle("abort");
    end else begin
      repeat (3) begin
        @(negedge clk);
        check_idle("hold");
      end
      counter_enable = 1'b0;
      @(negedge clk);
      check_idle("idle_after");
    end
  endtask

  task automatic cfg_bad(input int p, input int dl);
    @(negedge clk);
    Prescale = PW'(p); PAR_EN = 1'b0; STOP2 = 1'b0; data_len = 4'(dl);
    counter_enable = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_idle("cfg_bad");
      chk("cfg_err_set", 32'(cfg_err), 1);
    end
    counter_enable = 1'b0;
    @(negedge clk);
    chk("cfg_err_clear", 32'(cfg_err), 0);
    check_idle("cfg_clear");
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_idle("reset");
    chk("reset_cfg_err", 32'(cfg_err), 0);
    rst = 1'b1;
    @(negedge clk);
    check_idle("post_reset");

    run_frame(8, 1'b0, 1'b0, 8, 0, 0);    // L=10, 80 clocks
    run_frame(16, 1'b1, 1'b1, 9, 0, 0);   // L=13, 208 clocks
    run_frame(5, 1'b0, 1'b0, 5, 0, 0);    // odd P, M=2
    run_frame(8, 1'b0, 1'b0, 8, 20, 0);   // live config change ignored
    run_frame(8, 1'b0, 1'b0, 8, 0, 33);   // abort on first clock of bit 4

    cfg_bad(3, 8);
    cfg_bad(8, 4);
    cfg_bad(8, 10);

    // Asynchronous reset mid-frame, at a sample point
    @(negedge clk);
    Prescale = PW'(8); data_len = 4'd8; PAR_EN = 1'b0; STOP2 = 1'b0;
    counter_enable = 1'b1;
    repeat (12) @(negedge clk);
    chk("pre_rst_strobe", 32'(sample_strobe), 1);
    rst = 1'b0;
    #1;
    check_idle("async_rst");
    chk("async_rst_cfg_err", 32'(cfg_err), 0);
    counter_enable = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_idle("after_rst_release");

    chk("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/uart_rx_timing_counter.md
UART_RX_TIMING_COUNTER -- requirements
Module: uart_rx_timing_counter

Interface
REQ-001 Parameter PRESC_W, 6: width of Prescale and edge_count; legal 3..8.
REQ-002 Parameter DATA_BITS_MAX, 9: largest accepted data_len; legal 5..12.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 Prescale  input  PRESC_W  oversampling ratio P (clocks per bit); legal 4..2^PRESC_W-1.
REQ-006 counter_enable  input  1  high = frame in progress; low = abort/idle.
REQ-007 PAR_EN  input  1  frame carries one parity bit.
REQ-008 STOP2  input  1  frame carries two stop bits (else one).
REQ-009 data_len  input  4  data bits per frame; legal 5..DATA_BITS_MAX.
REQ-010 edge_count  output  PRESC_W  clock index within current bit, 0..P-1.
REQ-011 bit_count  output  4  bit index within frame, 0 = start bit.
REQ-012 sample_strobe  output  1  high on each of the three majority-vote sample edges.
REQ-013 sample_last  output  1  high on the third (final) sample edge only.
REQ-014 bit_done  output  1  high on the last clock of every bit (edge_count == P-1).
REQ-015 frame_done  output  1  one-cycle pulse on the last clock of the frame.
REQ-016 cfg_err  output  1  configuration captured at frame start was illegal.

Function
REQ-017 Three states SHALL exist: IDLE, COUNT, HOLD.
REQ-018 In IDLE, edge_count and bit_count SHALL be 0; all strobes low.
REQ-019 IDLE with counter_enable sampled high SHALL latch P, PAR_EN, STOP2 and data_len, then enter COUNT with edge_count = 0 and bit_count = 0, provided the configuration is legal.
REQ-020 Frame length L = 1 + data_len + PAR_EN + (STOP2 ? 2 : 1); range 7..DATA_BITS_MAX+4.
REQ-021 In COUNT, edge_count SHALL increment every clock; at P-1 it wraps to 0 and bit_count increments.
REQ-022 Input changes to Prescale, PAR_EN, STOP2 or data_len during COUNT or HOLD SHALL be ignored; latched copies govern the whole frame.
REQ-023 Centre M = floor(P/2); sample_strobe high when in COUNT and edge_count ∈ {M-1, M, M+1}; sample_last high when edge_count == M+1.
REQ-024 All strobes SHALL be combinational decodes of registered state, valid in the same cycle as the matching counter value.
REQ-025 frame_done SHALL be high in the COUNT cycle where bit_count == L-1 and edge_count == P-1; bit_done is also high in that cycle.
REQ-026 The next state after frame_done SHALL be HOLD, with counters 0; bit_count never exceeds L-1.
REQ-027 HOLD SHALL persist while counter_enable is high; counter_enable low SHALL return to IDLE.
REQ-028 A new frame therefore requires counter_enable low for at least one clock.
REQ-029 counter_enable low in COUNT SHALL return to IDLE next edge, counters 0, with no frame_done.
REQ-030 Illegal config at start (P < 4 or data_len outside 5..DATA_BITS_MAX) SHALL keep IDLE and counters at 0.
REQ-031 In that case cfg_err SHALL be set; it stays high until counter_enable goes low.
REQ-032 Latency: frame_done SHALL occur exactly P*L clocks after the edge that samples counter_enable high in IDLE.

Reset
REQ-033 rst low SHALL immediately, without a clock edge, force IDLE and all outputs 0.
REQ-034 This holds in any state, including mid-frame.
REQ-035 The first frame after rst release SHALL require counter_enable sampled high in IDLE.

Verification
REQ-036 P=8, PAR_EN=0, STOP2=0, data_len=8 -> L=10; bit_count 0..9; sample_strobe at edge 3,4,5 of every bit; frame_done exactly 80 clocks after enable.
REQ-037 P=16, PAR_EN=1, STOP2=1, data_len=9 -> L=13; frame_done at clock 208; then HOLD with counters 0 until enable drops.
REQ-038 P=5 (odd) -> M=2; strobes at edge_count 1,2,3; sample_last at 3; bit_done at 4.
REQ-039 P=3 or data_len=4 at enable -> cfg_err=1; counters stay 0; no strobes; cfg_err clears when enable goes low.
REQ-040 P=8 frame; Prescale changed to 32 at clock 20 -> ignored; frame_done still at clock 80.
REQ-041 Abort: enable low at bit_count=4 -> IDLE next edge, no frame_done. Reset: rst low mid-frame -> all outputs 0 asynchronously, before the next clock edge.
